// File: rtl/cxl_llr_pkg.sv
// Shared types and constants for the CXL link-layer retry (LLR) transmit path.
package cxl_llr_pkg;

  localparam int SEQ_W = 8;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    LLR_TX_IDLE   = 2'd0,
    LLR_TX_ACK    = 2'd1,
    LLR_TX_REPLAY = 2'd2
  } llr_tx_state_e;

  typedef struct packed {
    logic             empty;
    logic [CNT_W-1:0] num_retry;
    logic [CNT_W-1:0] num_phy_reinit;
    logic [SEQ_W-1:0] wrptr;
  } retry_ack_t;

  function automatic logic [SEQ_W-1:0] seq_min(input logic [SEQ_W-1:0] a,
                                               input logic [SEQ_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cxl_llr_retry_buf.sv
// Retry buffer storage: one write port and one registered read port with read enable.
module cxl_llr_retry_buf #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 528,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cxl_llr_tx_replay.sv
// Transmit-side LLR controller: retry buffer, RETRY.Ack responder and replay engine.
// Optional saturating statistics outputs are enabled by defining CXL_LLR_REPLAY_STATS_EN.
module cxl_llr_tx_replay
  import cxl_llr_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 528
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_tx_flit_valid,
  output logic                       o_tx_flit_ready,
  input  logic [DATA_W-1:0]          i_tx_flit_data,
  output logic [7:0]                 o_tx_seq,
  input  logic                       i_ack_valid,
  input  logic [$clog2(DEPTH+1)-1:0] i_ack_num,
  input  logic                       i_retry_req_valid,
  input  logic [7:0]                 i_retry_req_eseq,
  input  logic [4:0]                 i_retry_req_num_retry,
  input  logic [4:0]                 i_retry_req_num_phy_reinit,
  output logic                       o_retry_ack_valid,
  input  logic                       i_retry_ack_ready,
  output logic                       o_retry_ack_empty,
  output logic [4:0]                 o_retry_ack_num_retry,
  output logic [4:0]                 o_retry_ack_num_phy_reinit,
  output logic [7:0]                 o_retry_ack_wrptr,
  output logic                       o_replay_valid,
  input  logic                       i_replay_ready,
  output logic [DATA_W-1:0]          o_replay_data,
  output logic [7:0]                 o_replay_seq,
  output logic [$clog2(DEPTH+1)-1:0] o_free_entries,
  output logic                       o_seq_err,
  output logic [1:0]                 o_dbg_state
`ifdef CXL_LLR_REPLAY_STATS_EN
  ,
  output logic [15:0]                o_stat_retry_cnt,
  output logic [15:0]                o_stat_replay_flits
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Handshakes: a transfer happens on a cycle where valid && ready; once valid
  // is raised the source holds valid and its payload stable until that cycle.

  llr_tx_state_e    state_q, state_d;
  logic [SEQ_W-1:0] wr_seq_q, wr_seq_d, oldest_q, oldest_d, rd_seq_q, rd_seq_d;
  logic [SEQ_W-1:0] rseq_q, rseq_d;
  logic [CW-1:0]    pend_q, pend_d, pend_sat;
  logic [CW:0]      pend_sum;
  retry_ack_t       ack_q, ack_d;
  logic             rvalid_q, rvalid_d, seq_err_q, seq_err_d;
  logic [SEQ_W-1:0] count, wr_seq_w, cnt_w, oldest_a, rel;
  logic             wr_en, rd_en, rep_hs, to_idle, retry_ok, retry_eq;

  assign count           = wr_seq_q - oldest_q;
  assign o_tx_flit_ready = (state_q == LLR_TX_IDLE) && (count < SEQ_W'(DEPTH));
  assign wr_en           = i_tx_flit_valid && o_tx_flit_ready;
  assign rep_hs          = rvalid_q && i_replay_ready;

  always_comb begin
    state_d   = state_q;
    oldest_d  = oldest_q;
    rd_seq_d  = rd_seq_q;
    pend_d    = pend_q;
    ack_d     = ack_q;
    rvalid_d  = rvalid_q && !rep_hs;
    rseq_d    = rseq_q;
    seq_err_d = 1'b0;
    rd_en     = 1'b0;
    to_idle   = 1'b0;

    // Same-cycle ordering in IDLE: write, then ack, then retry evaluation.
    wr_seq_w = wr_seq_q + SEQ_W'(wr_en);
    wr_seq_d = wr_seq_w;
    cnt_w    = wr_seq_w - oldest_q;
    oldest_a = oldest_q;
    if (i_ack_valid && state_q == LLR_TX_IDLE)
      oldest_a = oldest_q + seq_min(SEQ_W'(i_ack_num), cnt_w);
    oldest_d = oldest_a;
    rel      = i_retry_req_eseq - oldest_a;
    retry_ok = rel < (wr_seq_w - oldest_a);
    retry_eq = i_retry_req_eseq == wr_seq_w;

    pend_sum = {1'b0, pend_q} + (i_ack_valid ? {1'b0, i_ack_num} : '0);
    pend_sat = (pend_sum > (CW+1)'(DEPTH)) ? CW'(DEPTH) : pend_sum[CW-1:0];

    if (i_retry_req_valid) begin
      state_d              = LLR_TX_ACK;
      rvalid_d             = 1'b0;
      ack_d.num_retry      = i_retry_req_num_retry;
      ack_d.num_phy_reinit = i_retry_req_num_phy_reinit;
      ack_d.wrptr          = wr_seq_w;
      ack_d.empty          = 1'b1;
      if (retry_ok) begin
        oldest_d    = i_retry_req_eseq;
        rd_seq_d    = i_retry_req_eseq;
        ack_d.empty = 1'b0;
      end else if (retry_eq) begin
        oldest_d = wr_seq_w;
      end else begin
        seq_err_d = 1'b1;
      end
      if (state_q != LLR_TX_IDLE) pend_d = pend_sat;
    end else begin
      case (state_q)
        LLR_TX_ACK: begin
          pend_d = pend_sat;
          if (i_retry_ack_ready) begin
            if (!ack_q.empty) begin
              state_d  = LLR_TX_REPLAY;
              rd_en    = 1'b1;
              rvalid_d = 1'b1;
              rseq_d   = rd_seq_q;
              rd_seq_d = rd_seq_q + 8'd1;
            end else begin
              state_d = LLR_TX_IDLE;
              to_idle = 1'b1;
            end
          end
        end
        LLR_TX_REPLAY: begin
          pend_d = pend_sat;
          if (rep_hs && rseq_q == wr_seq_q - 8'd1) begin
            state_d = LLR_TX_IDLE;
            to_idle = 1'b1;
          end else if ((!rvalid_q || i_replay_ready) && rd_seq_q != wr_seq_q) begin
            rd_en    = 1'b1;
            rvalid_d = 1'b1;
            rseq_d   = rd_seq_q;
            rd_seq_d = rd_seq_q + 8'd1;
          end
        end
        default: ;
      endcase
    end

    // Acks collected while busy are released on the way back to IDLE.
    if (to_idle) begin
      oldest_d = oldest_q + seq_min(SEQ_W'(pend_sat), count);
      pend_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= LLR_TX_IDLE;
      wr_seq_q  <= '0;
      oldest_q  <= '0;
      rd_seq_q  <= '0;
      pend_q    <= '0;
      ack_q     <= '0;
      rvalid_q  <= 1'b0;
      rseq_q    <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_seq_q  <= wr_seq_d;
      oldest_q  <= oldest_d;
      rd_seq_q  <= rd_seq_d;
      pend_q    <= pend_d;
      ack_q     <= ack_d;
      rvalid_q  <= rvalid_d;
      rseq_q    <= rseq_d;
      seq_err_q <= seq_err_d;
    end
  end

  cxl_llr_retry_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_buf (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_seq_q[AW-1:0]),
    .wr_data (i_tx_flit_data),
    .rd_en   (rd_en),
    .rd_addr (rd_seq_q[AW-1:0]),
    .rd_data (o_replay_data)
  );

  assign o_tx_seq                   = wr_seq_q;
  assign o_free_entries             = CW'(DEPTH) - CW'(count);
  assign o_retry_ack_valid          = (state_q == LLR_TX_ACK);
  assign o_retry_ack_empty          = ack_q.empty;
  assign o_retry_ack_num_retry      = ack_q.num_retry;
  assign o_retry_ack_num_phy_reinit = ack_q.num_phy_reinit;
  assign o_retry_ack_wrptr          = ack_q.wrptr;
  assign o_replay_valid             = rvalid_q;
  assign o_replay_seq               = rseq_q;
  assign o_seq_err                  = seq_err_q;
  assign o_dbg_state                = state_q;

`ifdef CXL_LLR_REPLAY_STATS_EN
  logic [15:0] stat_retry_q, stat_flits_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stat_retry_q <= '0;
      stat_flits_q <= '0;
    end else begin
      if (i_retry_req_valid && stat_retry_q != 16'hffff) stat_retry_q <= stat_retry_q + 16'd1;
      if (rep_hs && stat_flits_q != 16'hffff)            stat_flits_q <= stat_flits_q + 16'd1;
    end
  end

  assign o_stat_retry_cnt    = stat_retry_q;
  assign o_stat_replay_flits = stat_flits_q;
`endif

endmodule

// File: doc/cxl_llr_tx_replay.md
# cxl_llr_tx_replay

Transmit-side link-layer retry (LLR) controller for the CXL controller; it is the responder to the receiver's RETRY.Req path. It holds every sequenced flit the transmitter sends in a circular retry buffer until the remote side acknowledges it. On a remote RETRY.Req it issues a RETRY.Ack that echoes the requester's retry/PHY-reinit counts, then replays the buffer from the expected sequence number. It sits between the TX flit packer and the TX flit mux.

## Interface
- DEPTH, 16: retry buffer entries; power of 2, 2..128.
- DATA_W, 528: flit payload width.
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tx_flit_valid / o_tx_flit_ready  in/out  1  new sequenced flit handshake.
- i_tx_flit_data  in  DATA_W  flit to store.
- o_tx_seq  out  8  sequence number assigned to the current write (= wr_seq).
- i_ack_valid  in  1  remote Full_Ack/ack-count strobe.
- i_ack_num  in  $clog2(DEPTH+1)  entries freed (oldest first).
- i_retry_req_valid  in  1  RETRY.Req received.
- i_retry_req_eseq  in  8  expected sequence number.
- i_retry_req_num_retry, i_retry_req_num_phy_reinit  in  5 each  requester counters.
- o_retry_ack_valid / i_retry_ack_ready  out/in  1  RETRY.Ack handshake.
- o_retry_ack_empty  out  1  nothing to replay.
- o_retry_ack_num_retry, o_retry_ack_num_phy_reinit  out  5 each  echoed counters.
- o_retry_ack_wrptr  out  8  wr_seq at request capture.
- o_replay_valid / i_replay_ready  out/in  1  replay flit handshake.
- o_replay_data  out  DATA_W; o_replay_seq  out  8.
- o_free_entries  out  $clog2(DEPTH+1)  DEPTH − count.
- o_seq_err  out  1  one-cycle pulse: eseq outside window.

## Operation
- State: wr_seq, oldest (8-bit, wrap mod 256); count = wr_seq − oldest (mod 256); entry address = seq[$clog2(DEPTH)-1:0].
- Write: accepted when valid && ready; stores data, wr_seq++. o_tx_flit_ready = (state==IDLE) && count<DEPTH.
- Ack in IDLE: oldest += min(i_ack_num, count). Acks outside IDLE accumulate in pending_ack, which saturates at DEPTH; pending_ack is applied in the cycle the FSM re-enters IDLE.
- FSM IDLE→ACK on i_retry_req_valid:
  - Capture the echoed counters and o_retry_ack_wrptr = wr_seq.
  - eseq in [oldest, wr_seq): oldest := eseq (implicit free), empty=0, rd_seq := eseq.
  - eseq == wr_seq: oldest := wr_seq, empty=1.
  - Otherwise: o_seq_err pulse, empty=1, oldest unchanged.
- ACK: hold o_retry_ack_valid with stable fields until ready. On handshake go to REPLAY if empty=0, else IDLE.
- REPLAY: stream entries rd_seq..wr_seq−1 with o_replay_seq = rd_seq and rd_seq++ per handshake. Go to IDLE after the handshake of the entry at wr_seq−1. Entries are not freed by replay.
- A new i_retry_req_valid in ACK or REPLAY aborts the current activity. It is re-evaluated as in IDLE against the current oldest/wr_seq, and the FSM re-enters ACK next cycle; any replay flit held on the output is dropped.

## Timing
- Reset: state IDLE, wr_seq=oldest=0, pending_ack=0, all valid outputs 0, all data/field outputs 0, o_free_entries=DEPTH, o_tx_flit_ready=1.
- o_tx_seq, o_tx_flit_ready and o_free_entries are combinational from registers. o_free_entries reflects a write or ack the cycle after it.
- Retry req at cycle N: o_retry_ack_valid is high at N+1.
- Replay output is registered and read from the array. The first o_replay_valid is 1 cycle after the ACK handshake; back-to-back at 1 flit/cycle while ready is high. Data and seq stay stable while valid && !ready.
- Same-cycle events in IDLE, applied in this order: write, then ack, then retry. The eseq window check uses oldest after the ack and wr_seq after the write.
- 8-bit wrap: window comparison is done on (seq − oldest) mod 256 < count.

## Configuration
- CXL_LLR_REPLAY_STATS_EN defined: adds two 16-bit saturating outputs.
  - o_stat_retry_cnt: increments per accepted RETRY.Req.
  - o_stat_replay_flits: increments per replay handshake.
  - Both reset to 0.
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Structure
- cxl_llr_pkg holds:
  - the state enum (LLR_TX_IDLE, LLR_TX_ACK, LLR_TX_REPLAY);
  - SEQ_W=8 and the 5-bit counter width constant;
  - a retry_ack_t struct (empty, num_retry, num_phy_reinit, wrptr).
- Sub-module cxl_llr_retry_buf: DEPTH×DATA_W storage with one write port and one registered read port with read enable. The FSM, pointers and pending_ack live in the top module.

## Test plan
- Write 5 flits → o_tx_seq 0..4, o_free_entries=11. Ack num=3 → o_free_entries=14, oldest=3.
- Buffer holds seq 0..4; RETRY.Req eseq=2, num_retry=1, num_phy_reinit=0 → ack empty=0, wrptr=5, counters echoed; replay seq 2,3,4 with the stored data; o_free_entries=13.
- RETRY.Req with eseq == wr_seq=5 → ack empty=1, no replay, o_free_entries=16.
- RETRY.Req eseq=9 with window [0,5) → o_seq_err pulse, ack empty=1, o_free_entries unchanged.
- Fill 16 entries → o_tx_flit_ready=0. Ack 4 during REPLAY → pending; after IDLE re-entry o_free_entries reflects +4.
- wr_seq wrapped: write seq 250..255 then 0..3 with DEPTH=16. eseq=254 → replay 254,255,0,1,2,3. i_replay_ready low for 3 cycles mid-stream → o_replay_data and o_replay_seq hold.
